ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
Parameters:
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr  out  32  fetch address; word aligned.
REQ-006 The block SHALL have port imem_ack  in  1  memory returns data this cycle.
REQ-007 The block SHALL have port imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port if_valid  out  1  held instruction offered to decode.
REQ-009 The block SHALL have port id_ready  in  1  decode accepts; handshake occurs when if_valid=1 and id_ready=1.
REQ-010 The block SHALL have port if_instr  out  32  held instruction word.
REQ-011 The block SHALL have port if_pc  out  32  address of if_instr.
REQ-012 The block SHALL have port if_pc4  out  32  if_pc+4; this is the PC4 input of the next-PC unit.
REQ-013 The block SHALL have port redirect  in  1  the instruction accepted this cycle is a taken branch or jump.
REQ-014 The block SHALL have port npc_target  in  32  next-PC unit output NPCout, used when redirect=1.
REQ-015 The block SHALL have port flush  in  1  exception or eret redirect, valid in any cycle.
REQ-016 The block SHALL have port flush_pc  in  32  target address for flush.

Function
REQ-017 The block SHALL implement states FETCH, FULL and DROP.
REQ-018 The block SHALL hold registers pc (next fetch address) and req_addr; imem_addr SHALL equal req_addr.
REQ-019 imem_req SHALL be 1 in FETCH and DROP and 0 in FULL.
REQ-020 req_addr SHALL stay constant while imem_req=1 until imem_ack=1.
REQ-021 In FETCH with imem_ack=1 and no flush, the block SHALL latch if_instr<=imem_rdata, if_pc<=req_addr, if_pc4<=req_addr+4 and pc<=req_addr+4, then go to FULL.
REQ-022 Zero-wait memory (imem_ack in the first request cycle) SHALL be supported, so the minimum fetch latency is 1 cycle from request to if_valid.
REQ-023 In FULL, if_valid SHALL be 1 and if_instr, if_pc and if_pc4 SHALL hold steady while id_ready=0.
REQ-024 In FULL, on a handshake with redirect=0, the block SHALL go to FETCH with req_addr<=pc.
REQ-025 In FULL, on a handshake with redirect=1, the block SHALL set pc<=npc_target and go to FETCH with req_addr<=npc_target.
REQ-026 redirect SHALL be ignored unless a handshake occurs in the same cycle.
REQ-027 flush SHALL have priority over redirect, handshake and imem_ack.
REQ-028 When flush=1, the block SHALL set pc<=flush_pc and if_valid<=0 in every state.
REQ-029 A flush in FULL SHALL discard the held instruction and go to FETCH with req_addr<=flush_pc.
REQ-030 A flush in FETCH with imem_ack=1 SHALL discard the data and go to FETCH with req_addr<=flush_pc.
REQ-031 A flush in FETCH with imem_ack=0 SHALL go to DROP with req_addr unchanged.
REQ-032 In DROP, the block SHALL keep requesting req_addr.
REQ-033 In DROP, on imem_ack=1 the block SHALL discard the data and go to FETCH with req_addr<=pc.
REQ-034 A further flush in DROP SHALL update pc only.
REQ-035 Bits [1:0] of npc_target, flush_pc, pc and req_addr SHALL be forced to 2'b00.
REQ-036 All address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-037 if_valid SHALL be 0 in FETCH and DROP.

Reset
REQ-038 While reset=1, the block SHALL force state FETCH, pc=req_addr=RESET_PC, if_valid=0 and if_instr=if_pc=if_pc4=0.
REQ-039 While reset=1, imem_req SHALL be 0.
REQ-040 On the first cycle after reset, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-041 Reset SHALL override flush, redirect and imem_ack.
REQ-042 Reset mid-operation (FULL or DROP) SHALL return the block to the post-reset state on the next edge, abandoning any outstanding request.

Verification
REQ-043 The bench SHALL cover startup: reset for 2 cycles, then ack 0x24080001 after 2 wait cycles -> if_valid=1, if_instr=0x24080001, if_pc=0x3000, if_pc4=0x3004.
REQ-044 The bench SHALL cover backpressure: id_ready=0 for 3 cycles in FULL -> outputs stable, imem_req=0; then id_ready=1 -> next cycle imem_addr=0x3004.
REQ-045 The bench SHALL cover redirect: handshake with redirect=1 and npc_target=0x3100 -> next imem_addr=0x3100; redirect=1 without handshake -> no effect.
REQ-046 The bench SHALL cover flush mid-fetch: request 0x3008 outstanding, flush=1 with flush_pc=0x4180 -> DROP, imem_addr held at 0x3008, ack data discarded with if_valid=0, next request 0x4180.
REQ-047 The bench SHALL cover flush with same-cycle ack and with handshake: data or instruction discarded -> next request 0x4180 directly, redirect ignored.
REQ-048 The bench SHALL cover reset in FULL: next cycle if_valid=0, imem_req=0; after release imem_addr=0x3000.

Source files
------------

// File: rtl/ifu.sv
// ifu: instruction fetch unit with a one-entry holding register and a drop state
// that swallows the reply of a request abandoned by a flush.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        redirect,
    input  logic [31:0] npc_target,
    input  logic        flush,
    input  logic [31:0] flush_pc
);
    localparam logic [31:0] RPC = {RESET_PC[31:2], 2'b00};
    typedef enum logic [1:0] {FETCH, FULL, DROP} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, req_addr, req_n, fpc, npc;
    logic        ld, hs;
    assign fpc       = {flush_pc[31:2], 2'b00};
    assign npc       = {npc_target[31:2], 2'b00};
    assign hs        = state == FULL && id_ready;
    assign imem_req  = !reset && state != FULL;
    assign imem_addr = req_addr;
    assign if_valid  = state == FULL;
    // Flush wins over everything; a flush with a request still in flight parks in DROP.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = req_addr;
        ld      = 1'b0;
        if (flush) begin
            pc_n = fpc;
            if (state == FULL || (state == FETCH && imem_ack)) begin
                state_n = FETCH;
                req_n   = fpc;
            end else if (state == FETCH) state_n = DROP;
        end else if (hs) begin
            state_n = FETCH;
            req_n   = redirect ? npc : pc;
            pc_n    = redirect ? npc : pc;
        end else if (state == FETCH && imem_ack) begin
            ld      = 1'b1;
            pc_n    = req_addr + 32'd4;
            state_n = FULL;
        end else if (state == DROP && imem_ack) begin
            state_n = FETCH;
            req_n   = pc;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RPC;
            req_addr <= RPC;
            if_instr <= '0;
            if_pc    <= '0;
            if_pc4   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_n;
            if (ld) begin
                if_instr <= imem_rdata;
                if_pc    <= req_addr;
                if_pc4   <= req_addr + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed scenarios plus randomized traffic checked every cycle against
// a transaction-level model of the fetch unit.
module tb_ifu;
    logic        clk = 0, reset, imem_ack, id_ready, redirect, flush;
    logic [31:0] imem_rdata, npc_target, flush_pc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc, if_pc4;
    int          tests = 0, fails = 0;
    // model: held instruction, pending-discard flag, next pc and outstanding address
    logic        m_held, m_discard;
    logic [31:0] m_pc, m_req, m_instr, m_ipc;

    ifu dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
        .redirect(redirect), .npc_target(npc_target), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; imem_ack = 0; id_ready = 0; redirect = 0; flush = 0;
        imem_rdata = 0; npc_target = 0; flush_pc = 0;
    endtask

    task automatic model_step();
        logic [31:0] f, n;
        f = flush_pc & ~32'd3;
        n = npc_target & ~32'd3;
        if (reset) begin
            m_held = 0; m_discard = 0; m_pc = 32'h3000; m_req = 32'h3000; m_instr = 0; m_ipc = 0;
        end else if (flush) begin
            m_pc = f;
            if (m_held) begin
                m_held = 0; m_req = f;
            end else if (!m_discard) begin
                if (imem_ack) m_req = f;
                else m_discard = 1;
            end
        end else if (m_held) begin
            if (id_ready) begin
                m_held = 0;
                if (redirect) m_pc = n;
                m_req = m_pc;
            end
        end else if (imem_ack) begin
            if (m_discard) begin
                m_discard = 0; m_req = m_pc;
            end else begin
                m_held = 1; m_instr = imem_rdata; m_ipc = m_req; m_pc = m_req + 4;
            end
        end
    endtask

    task automatic check_model();
        chk("m_req", imem_req, !reset && !m_held);
        chk("m_addr", imem_addr, m_req);
        chk("m_valid", if_valid, m_held);
        if (m_held) begin
            chk("m_instr", if_instr, m_instr);
            chk("m_pc", if_pc, m_ipc);
            chk("m_pc4", if_pc4, m_ipc + 4);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        idle();
        m_held = 0; m_discard = 0; m_pc = 32'h3000; m_req = 32'h3000; m_instr = 0; m_ipc = 0;
        reset = 1;
        @(negedge clk);
        step(); step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        reset = 0;
        #1 chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, 32'h3000);
        step(); step();
        chk("wait_addr", imem_addr, 32'h3000);
        imem_ack = 1; imem_rdata = 32'h2408_0001;
        step();
        imem_ack = 0;
        chk("start_valid", if_valid, 1);
        chk("start_instr", if_instr, 32'h2408_0001);
        chk("start_pc", if_pc, 32'h3000);
        chk("start_pc4", if_pc4, 32'h3004);
        repeat (3) begin
            step();
            chk("bp_valid", if_valid, 1);
            chk("bp_req", imem_req, 0);
            chk("bp_instr", if_instr, 32'h2408_0001);
            chk("bp_pc", if_pc, 32'h3000);
        end
        id_ready = 1;
        step();
        id_ready = 0;
        chk("bp_next", imem_addr, 32'h3004);
        imem_ack = 1; imem_rdata = 32'h1111_2222;
        step();
        imem_ack = 0; id_ready = 1;
        step();
        id_ready = 0;
        chk("seq_addr", imem_addr, 32'h3008);
        flush = 1; flush_pc = 32'h4180;
        step();
        flush = 0;
        chk("drop_hold", imem_addr, 32'h3008);
        chk("drop_req", imem_req, 1);
        step();
        chk("drop_hold2", imem_addr, 32'h3008);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 0;
        chk("drop_valid", if_valid, 0);
        chk("drop_next", imem_addr, 32'h4180);
        redirect = 1; npc_target = 32'h3200;
        step();
        redirect = 0;
        chk("rd_nohs_fetch", imem_addr, 32'h4180);
        imem_ack = 1; imem_rdata = 32'h0800_0040;
        step();
        imem_ack = 0; redirect = 1; npc_target = 32'h3200;
        step();
        chk("rd_nohs_full", if_valid, 1);
        id_ready = 1; npc_target = 32'h3100;
        step();
        id_ready = 0; redirect = 0;
        chk("rd_target", imem_addr, 32'h3100);
        flush = 1; flush_pc = 32'h4181; imem_ack = 1;
        step();
        flush = 0; imem_ack = 0;
        chk("fl_ack_valid", if_valid, 0);
        chk("fl_ack_addr", imem_addr, 32'h4180);
        imem_ack = 1;
        step();
        imem_ack = 0; flush = 1; flush_pc = 32'h4180; id_ready = 1; redirect = 1; npc_target = 32'h3100;
        step();
        idle();
        chk("fl_hs_valid", if_valid, 0);
        chk("fl_hs_addr", imem_addr, 32'h4180);
        imem_ack = 1;
        step();
        imem_ack = 0; reset = 1;
        step();
        chk("rf_valid", if_valid, 0);
        chk("rf_req", imem_req, 0);
        reset = 0;
        #1 chk("rf_addr", imem_addr, 32'h3000);
        chk("rf_req2", imem_req, 1);
        for (int i = 0; i < 3000; i++) begin
            reset      = $urandom_range(0, 99) == 0;
            flush      = $urandom_range(0, 9) == 0;
            imem_ack   = $urandom_range(0, 1) == 1;
            id_ready   = $urandom_range(0, 2) != 0;
            redirect   = $urandom_range(0, 1) == 1;
            imem_rdata = $urandom;
            npc_target = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC : $urandom;
            flush_pc   = $urandom;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
